// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer.
// Holds the 128-bit cipher state and runs it through an external combinational
// round datapath one round per cycle. Round keys are fetched from the key
// schedule with a request/valid handshake, and blocks enter and leave on
// valid/ready streams.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  data_out,
  input  logic          abort,
  output logic          busy,
  output logic          rk_req,
  output logic [RW-1:0] rk_idx,
  input  logic          rk_valid,
  input  logic [127:0]  rk_data,
  output logic [127:0]  dp_state,
  output logic [127:0]  dp_key,
  output logic          dp_mix_byp,
  input  logic [127:0]  dp_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY0  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic [RW-1:0] LAST_ROUND = RW'(NR);
  localparam logic [RW-1:0] FIRST_ROUND = RW'(1);

  fsm_t          fsm;
  fsm_t          fsm_nxt;
  logic [RW-1:0] round;
  logic [RW-1:0] round_nxt;
  logic [127:0]  state;
  logic [127:0]  state_nxt;
  logic          last_round;

  assign last_round = (round == LAST_ROUND);

  // Controller registers: FSM, round counter and cipher state; reset drops any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      round <= '0;
      state <= '0;
    end else begin
      fsm   <= fsm_nxt;
      round <= round_nxt;
      state <= state_nxt;
    end
  end

  // Next-state logic: abort outranks key arrival and output acceptance, key stalls hold everything.
  always_comb begin
    fsm_nxt   = fsm;
    round_nxt = round;
    state_nxt = state;
    case (fsm)
      IDLE: begin
        if (in_valid) begin
          state_nxt = data_in;
          round_nxt = '0;
          fsm_nxt   = KEY0;
        end
      end
      KEY0: begin
        if (abort) begin
          round_nxt = '0;
          fsm_nxt   = IDLE;
        end else if (rk_valid) begin
          state_nxt = state ^ rk_data;
          round_nxt = FIRST_ROUND;
          fsm_nxt   = ROUND;
        end
      end
      ROUND: begin
        if (abort) begin
          round_nxt = '0;
          fsm_nxt   = IDLE;
        end else if (rk_valid) begin
          state_nxt = dp_result;
          if (last_round) begin
            fsm_nxt = DONE;
          end else begin
            round_nxt = round + 1'b1;
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          round_nxt = '0;
          fsm_nxt   = IDLE;
        end
      end
      default: begin
        round_nxt = '0;
        fsm_nxt   = IDLE;
      end
    endcase
  end

  // Output decodes straight from registered state; only dp_key is a combinational passthrough.
  assign in_ready   = (fsm == IDLE);
  assign out_valid  = (fsm == DONE);
  assign busy       = (fsm != IDLE);
  assign rk_req     = (fsm == KEY0) || (fsm == ROUND);
  assign rk_idx     = (fsm == ROUND) ? round : '0;
  assign dp_mix_byp = (fsm == ROUND) && last_round;
  assign data_out   = state;
  assign dp_state   = state;
  assign dp_key     = rk_data;

endmodule
